// File: rtl/addsub_pkg.sv
// ============================================================================
// Module : addsub_pkg
// Brief  : Shared types and constants for the add/subtract arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub_core.sv
// ============================================================================
// Module : addsub_core
// Brief  : Combinational WIDTH-bit add/subtract unit with WIDTH+1-bit result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic [WIDTH:0]   result
);

    // Bit WIDTH is carry-out for add and borrow for subtract.
    always_comb begin
        if (op == OP_ADD) begin
            result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end else begin
            result = {1'b0, a} - {1'b0, b};
        end
    end

endmodule

`default_nettype wire

// File: rtl/addsub_arbiter.sv
// ============================================================================
// Module : addsub_arbiter
// Brief  : Two-requester round-robin arbiter sequencing a shared add/sub unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH:0]     rsp_data,
    output logic               busy
);

    state_t             state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic               op_q,         op_d;
    logic [WIDTH-1:0]   a_q,          a_d;
    logic [WIDTH-1:0]   b_q,          b_d;
    logic               cin_q,        cin_d;
    logic               id_q,         id_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic               rsp_id_q,     rsp_id_d;
    logic [WIDTH:0]     rsp_data_q,   rsp_data_d;
    logic               busy_q,       busy_d;

    logic [1:0]         grant;
    logic               accept;
    logic               accept_id;
    logic [WIDTH:0]     core_result;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .cin    (cin_q),
        .op     (op_q),
        .result (core_result)
    );

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
        req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        accept_id = req_ready[1];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = req_op[accept_id];
                    a_d          = accept_id ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                    b_d          = accept_id ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                    cin_d        = req_cin[accept_id];
                    id_d         = accept_id;
                    last_grant_d = accept_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = core_result;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
// ============================================================================
// Module : tb_addsub_arbiter
// Brief  : Directed self-checking bench for addsub_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_addsub_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [8:0]  rsp_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    addsub_arbiter #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin);
        req_op[i]        = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_cin[i]       = cin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b id=%b data=%h busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, busy);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({req_ready, rsp_valid, busy} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b vld=%b busy=%b expected 0",
                     req_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_single_ops();
        logic        t_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        t_op   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0]  t_a    [4] = '{8'hFF, 8'h05, 8'h7F, 8'h7F};
        logic [7:0]  t_b    [4] = '{8'h01, 8'h07, 8'h80, 8'h80};
        logic        t_cin  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0]  t_exp  [4] = '{9'h100, 9'h1FE, 9'h100, 9'h0FF};
        logic [1:0]  exp_rdy;
        for (int k = 0; k < 4; k++) begin
            set_req(int'(t_id[k]), t_op[k], t_a[k], t_b[k], t_cin[k]);
            exp_rdy   = t_id[k] ? 2'b10 : 2'b01;
            req_valid = exp_rdy;
            #1;
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL single%0d_ready: got %b expected %b", k, req_ready, exp_rdy);
            end
            tick();
            req_valid = 2'b00;
            #1;
            n_tests++;
            if ({busy, rsp_valid, req_ready} !== 4'b1000) begin
                n_fail++;
                $display("FAIL single%0d_exec: got busy=%b vld=%b rdy=%b expected 1 0 00",
                         k, busy, rsp_valid, req_ready);
            end
            tick();
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, t_id[k], t_exp[k]}) begin
                n_fail++;
                $display("FAIL single%0d_rsp: got vld=%b id=%b data=%h expected 1 %b %h",
                         k, rsp_valid, rsp_id, rsp_data, t_id[k], t_exp[k]);
            end
            tick();
            n_tests++;
            if ({rsp_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL single%0d_done: got vld=%b busy=%b expected 0 0",
                         k, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic [8:0] exp_data;
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h10, 8'h20, 1'b0);
        set_req(1, 1'b0, 8'h30, 8'h10, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (k % 2 == 0) ? 9'h030 : 9'h020;
            n_tests++;
            if ({req_ready, busy} !== {exp_rdy, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b%0d_grant: got rdy=%b busy=%b expected %b 0",
                         k, req_ready, busy, exp_rdy);
            end
            tick();
            tick();
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, (k % 2 == 1), exp_data}) begin
                n_fail++;
                $display("FAIL b2b%0d_rsp: got vld=%b id=%b data=%h expected 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_data, k % 2, exp_data);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_grant0: got %b expected 01", req_ready);
        end
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, 1'b0, 9'h030, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got vld=%b id=%b data=%h rdy=%b busy=%b expected 1 0 030 00 1",
                         k, rsp_valid, rsp_id, rsp_data, req_ready, busy);
            end
            tick();
        end
        n_tests++;
        if ({rsp_valid, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_still: got vld=%b busy=%b expected 1 1", rsp_valid, busy);
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++;
        if ({rsp_valid, busy, req_ready} !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_release: got vld=%b busy=%b rdy=%b expected 0 0 10",
                     rsp_valid, busy, req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 9'h020}) begin
            n_fail++;
            $display("FAIL stall_next_rsp: got vld=%b id=%b data=%h expected 1 1 020",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        set_req(0, 1'b1, 8'h10, 8'h20, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy=%b vld=%b id=%b data=%h busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, busy);
        end
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen_valid++;
        end
        n_tests++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: got %0d busy/valid cycles expected 0", seen_valid);
        end
        req_valid = 2'b11;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_tie_grant: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 9'h030}) begin
            n_fail++;
            $display("FAIL midrst_rsp: got vld=%b id=%b data=%h expected 1 0 030",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_a     = 16'h0;
        req_b     = 16'h0;
        req_cin   = 2'b00;
        rsp_ready = 1'b1;

        test_reset();
        test_single_ops();
        test_back_to_back();
        test_stall();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
